// File: rtl/text_pkg.sv
// Shared encodings for the single-line text buffer: key commands, glyph constants
// and the controller FSM states.
package text_pkg;

  typedef enum logic [1:0] {
    CMD_WRITE     = 2'b00,
    CMD_BACKSPACE = 2'b01,
    CMD_CLEAR     = 2'b10,
    CMD_HOME      = 2'b11
  } key_cmd_t;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  // Wide constants; users cast them down to their glyph width.
  localparam logic [31:0] BLANK_GLYPH  = '0;
  localparam logic [31:0] CURSOR_GLYPH = '1;

endpackage

// File: rtl/text_store.sv
// COLS x CHAR_W single-port synchronous glyph RAM: one read or one write per cycle,
// registered read data that holds when no read is issued.
module text_store #(
  parameter int COLS   = 16,
  parameter int CHAR_W = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rd_en,
  input  logic                     wr_en,
  input  logic [$clog2(COLS)-1:0]  addr,
  input  logic [CHAR_W-1:0]        wdata,
  output logic [CHAR_W-1:0]        q
);

  logic [CHAR_W-1:0] mem [COLS];

  always_ff @(posedge clk) begin
    if (wr_en) mem[addr] <= wdata;
  end

  // Only the read register is reset; the array is cleared by the parent's CLEAR walk.
  always_ff @(posedge clk) begin
    if (reset)      q <= '0;
    else if (rd_en) q <= mem[addr];
  end

endmodule

// File: rtl/text_buffer_ctrl.sv
// Text buffer controller: key command slot, cursor/count tracking and read-priority
// arbitration of the glyph store. Optional cursor blink under macro CURSOR_BLINK_EN.
module text_buffer_ctrl
  import text_pkg::*;
#(
  parameter int COLS       = 16,
  parameter int CHAR_W     = 4,
  parameter int BLINK_LOG2 = 24
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      key_valid,
  input  logic [1:0]                key_cmd,
  input  logic [CHAR_W-1:0]         key_code,
  output logic                      key_ready,
  input  logic                      rd_req,
  input  logic [$clog2(COLS)-1:0]   rd_col,
  output logic                      rd_valid,
  output logic [CHAR_W-1:0]         rd_char,
  output logic [$clog2(COLS)-1:0]   cursor,
  output logic [$clog2(COLS):0]     count,
  output logic                      busy
);

  localparam int AW = $clog2(COLS);
  localparam logic [AW:0] FULL = (AW+1)'(COLS);

  state_t            state, state_nxt;
  logic [AW-1:0]     clr_addr, clr_addr_nxt;
  logic [AW-1:0]     cursor_nxt;
  logic [AW:0]       count_nxt;

  logic              pend_vld;
  key_cmd_t          pend_cmd;
  logic [CHAR_W-1:0] pend_code;
  logic              pend_free;
  logic              key_xfer;

  logic              st_we;
  logic [AW-1:0]     st_waddr;
  logic [AW-1:0]     st_addr;
  logic [CHAR_W-1:0] st_wdata;
  logic [CHAR_W-1:0] st_q;

  assign key_ready = !pend_vld && (state == ST_IDLE);
  assign key_xfer  = key_valid && key_ready;
  assign busy      = (state == ST_CLEAR);

  // Reads own the port; any update only proceeds on a cycle with rd_req low.
  always_comb begin
    state_nxt    = state;
    clr_addr_nxt = clr_addr;
    cursor_nxt   = cursor;
    count_nxt    = count;
    pend_free    = 1'b0;
    st_we        = 1'b0;
    st_waddr     = clr_addr;
    st_wdata     = CHAR_W'(BLANK_GLYPH);
    case (state)
      ST_CLEAR: begin
        if (!rd_req) begin
          st_we        = 1'b1;
          clr_addr_nxt = clr_addr + AW'(1);
          if (clr_addr == AW'(COLS - 1)) state_nxt = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (pend_vld && !rd_req) begin
          pend_free = 1'b1;
          case (pend_cmd)
            CMD_WRITE: begin
              st_we      = 1'b1;
              st_waddr   = cursor;
              st_wdata   = pend_code;
              cursor_nxt = cursor + AW'(1);
              count_nxt  = (count == FULL) ? count : count + (AW+1)'(1);
            end
            CMD_BACKSPACE: begin
              if (cursor != '0) begin
                st_we      = 1'b1;
                st_waddr   = cursor - AW'(1);
                cursor_nxt = cursor - AW'(1);
                count_nxt  = (count == '0) ? count : count - (AW+1)'(1);
              end
            end
            CMD_CLEAR: begin
              cursor_nxt   = '0;
              count_nxt    = '0;
              clr_addr_nxt = '0;
              state_nxt    = ST_CLEAR;
            end
            CMD_HOME: cursor_nxt = '0;
            default: ;
          endcase
        end
      end
      default: state_nxt = ST_CLEAR;
    endcase
  end

  assign st_addr = rd_req ? rd_col : st_waddr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_CLEAR;
      clr_addr <= '0;
      cursor   <= '0;
      count    <= '0;
      pend_vld <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      state    <= state_nxt;
      clr_addr <= clr_addr_nxt;
      cursor   <= cursor_nxt;
      count    <= count_nxt;
      rd_valid <= rd_req;
      if (pend_free)     pend_vld <= 1'b0;
      else if (key_xfer) pend_vld <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (key_xfer) begin
      pend_cmd  <= key_cmd_t'(key_cmd);
      pend_code <= key_code;
    end
  end

  text_store #(
    .COLS   (COLS),
    .CHAR_W (CHAR_W)
  ) u_store (
    .clk   (clk),
    .reset (reset),
    .rd_en (rd_req),
    .wr_en (st_we),
    .addr  (st_addr),
    .wdata (st_wdata),
    .q     (st_q)
  );

`ifdef CURSOR_BLINK_EN
  logic [BLINK_LOG2:0] blink_cnt;
  logic                blink_hit_p1;

  // The overlay decision is captured with the read so it stays aligned with rd_char.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt    <= '0;
      blink_hit_p1 <= 1'b0;
    end else begin
      blink_cnt <= blink_cnt + (BLINK_LOG2+1)'(1);
      if (rd_req)
        blink_hit_p1 <= blink_cnt[BLINK_LOG2] && (state == ST_IDLE) && (rd_col == cursor);
    end
  end

  assign rd_char = blink_hit_p1 ? CHAR_W'(CURSOR_GLYPH) : st_q;
`else
  logic blink_cfg_unused;
  assign blink_cfg_unused = (BLINK_LOG2 > 0);
  assign rd_char = st_q;
`endif

endmodule

// File: tb/tb_text_buffer_ctrl.sv
// Directed self-checking bench for text_buffer_ctrl (blink section active when
// CURSOR_BLINK_EN is defined).
module tb_text_buffer_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_valid;
  logic [1:0] key_cmd;
  logic [3:0] key_code;
  logic       key_ready;
  logic       rd_req;
  logic [3:0] rd_col;
  logic       rd_valid;
  logic [3:0] rd_char;
  logic [3:0] cursor;
  logic [4:0] count;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  text_buffer_ctrl #(
    .COLS       (16),
    .CHAR_W     (4),
    .BLINK_LOG2 (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .key_valid (key_valid),
    .key_cmd   (key_cmd),
    .key_code  (key_code),
    .key_ready (key_ready),
    .rd_req    (rd_req),
    .rd_col    (rd_col),
    .rd_valid  (rd_valid),
    .rd_char   (rd_char),
    .cursor    (cursor),
    .count     (count),
    .busy      (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] cmd, input logic [3:0] code);
    key_valid = 1'b1;
    key_cmd   = cmd;
    key_code  = code;
    for (int i = 0; i < 300 && !key_ready; i++) tick();
    chk("send_ready", key_ready, 1);
    tick();
    key_valid = 1'b0;
  endtask

  task automatic do_cmd(input logic [1:0] cmd, input logic [3:0] code);
    send(cmd, code);
    tick();
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] col, input logic [3:0] exp);
    rd_req = 1'b1;
    rd_col = col;
    tick();
    chk({tag, "_vld"}, rd_valid, 1);
    chk(tag, rd_char, exp);
    rd_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nf;
    reset = 1'b1; key_valid = 1'b0; key_cmd = 2'b00; key_code = 4'h0;
    rd_req = 1'b0; rd_col = 4'h0;
    repeat (2) tick();
    chk("rst_ready", key_ready, 0);
    chk("rst_rdvalid", rd_valid, 0);
    chk("rst_rdchar", rd_char, 0);
    chk("rst_cursor", cursor, 0);
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 1);
    reset = 1'b0;

    repeat (15) tick();
    chk("clr15_busy", busy, 1);
    tick();
    chk("clr16_busy", busy, 0);
    chk("clr16_ready", key_ready, 1);
    for (int c = 0; c < 16; c++) rd_chk("clr_read", 4'(c), 4'h0);
    tick();
    chk("rd_valid_drop", rd_valid, 0);

    do_cmd(2'b00, 4'h3);
    do_cmd(2'b00, 4'h5);
    do_cmd(2'b00, 4'h7);
    chk("w3_cursor", cursor, 3);
    chk("w3_count", count, 3);
    chk("w3_pre_vld", rd_valid, 0);
    rd_chk("w3_col0", 4'd0, 4'h3);
    rd_chk("w3_col1", 4'd1, 4'h5);
    rd_chk("w3_col2", 4'd2, 4'h7);

    rd_req = 1'b1; rd_col = 4'd3;
    send(2'b00, 4'h9);
    repeat (100) tick();
    chk("stall_ready", key_ready, 0);
    chk("stall_rdchar", rd_char, 0);
    chk("stall_cursor", cursor, 3);
    rd_req = 1'b0;
    tick();
    chk("land_ready", key_ready, 1);
    chk("land_cursor", cursor, 4);
    chk("land_count", count, 4);
    rd_chk("land_col3", 4'd3, 4'h9);

    do_cmd(2'b10, 4'h0);
    chk("clrcmd_busy", busy, 1);
    chk("clrcmd_cursor", cursor, 0);
    chk("clrcmd_count", count, 0);
    repeat (16) tick();
    chk("clrcmd_done", busy, 0);
    rd_chk("clrcmd_col3", 4'd3, 4'h0);

    for (int i = 0; i < 16; i++) do_cmd(2'b00, 4'(i + 1));
    chk("w16_cursor", cursor, 0);
    chk("w16_count", count, 16);
    do_cmd(2'b00, 4'hC);
    chk("w17_cursor", cursor, 1);
    chk("w17_count", count, 16);
    rd_chk("w17_col0", 4'd0, 4'hC);
    rd_chk("w17_col1", 4'd1, 4'h2);
    rd_chk("w17_col15", 4'd15, 4'h0);

    do_cmd(2'b11, 4'h0);
    chk("home_cursor", cursor, 0);
    chk("home_count", count, 16);
    do_cmd(2'b01, 4'h0);
    chk("bs0_cursor", cursor, 0);
    chk("bs0_count", count, 16);
    rd_chk("bs0_col0", 4'd0, 4'hC);
    do_cmd(2'b00, 4'h7);
    do_cmd(2'b00, 4'h8);
    chk("bs2_pre_cursor", cursor, 2);
    do_cmd(2'b01, 4'h0);
    chk("bs2_cursor", cursor, 1);
    chk("bs2_count", count, 15);
    rd_chk("bs2_col1", 4'd1, 4'h0);
    rd_chk("bs2_col0", 4'd0, 4'h7);

    rd_req = 1'b1; rd_col = 4'd5;
    send(2'b00, 4'hA);
    reset = 1'b1;
    tick();
    reset = 1'b0; rd_req = 1'b0;
    chk("mrst_busy", busy, 1);
    chk("mrst_ready", key_ready, 0);
    chk("mrst_cursor", cursor, 0);
    chk("mrst_count", count, 0);
    chk("mrst_rdvalid", rd_valid, 0);
    repeat (16) tick();
    chk("mrst_done", busy, 0);
    chk("mrst_ready2", key_ready, 1);
    chk("mrst_cursor2", cursor, 0);
    rd_chk("mrst_col1", 4'd1, 4'h0);

`ifdef CURSOR_BLINK_EN
    rd_req = 1'b1; rd_col = 4'd0;
    tick();
    nf = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      if (rd_char == 4'hF) nf++;
    end
    chk("blink_cursor_col", nf, 16);
    rd_col = 4'd1;
    nf = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      if (rd_char == 4'hF) nf++;
    end
    chk("blink_other_col", nf, 0);
    rd_req = 1'b0;
`else
    nf = 0;
`endif

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
